// File: rtl/wave_rom_fetch.sv
// Wave ROM fetch: per-channel one-word byte caches with round-robin miss
// arbitration onto a single req/ack 16-bit memory port, plus the slot counter.

module wave_rom_lane #(
    parameter int AW = 28
) (
    input  logic          I_CLK,
    input  logic          I_RSTn,
    input  logic [AW-1:0] I_ADDR,
    input  logic          I_INVALIDATE,
    input  logic          I_FILL,
    input  logic [15:0]   I_FILL_WORD,
    input  logic [AW-2:0] I_FILL_TAG,
    output logic          O_HIT,
    output logic          O_READY,
    output logic [7:0]    O_DATA
);
    logic [15:0]   word;
    logic [AW-2:0] tag;
    logic          valid;

    assign O_HIT = valid && (tag == I_ADDR[AW-1:1]);

    // Ready/data track the current address every clock, whether or not the
    // player is reading, so a returning player sees a fresh answer at once.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            word    <= '0;
            tag     <= '0;
            valid   <= 1'b0;
            O_READY <= 1'b0;
            O_DATA  <= '0;
        end else begin
            if (I_INVALIDATE) begin
                valid <= 1'b0;
            end else if (I_FILL) begin
                word  <= I_FILL_WORD;
                tag   <= I_FILL_TAG;
                valid <= 1'b1;
            end
            O_READY <= O_HIT;
            O_DATA  <= I_ADDR[0] ? word[15:8] : word[7:0];
        end
    end
endmodule

module wave_rom_fetch #(
    parameter int NCH = 8,
    parameter int AW  = 28
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic [NCH-1:0]    I_CH_READ,
    input  logic [NCH*AW-1:0] I_CH_ADDR,
    input  logic              I_INVALIDATE,
    output logic [NCH*8-1:0]  O_CH_DATA,
    output logic [NCH-1:0]    O_CH_READY,
    output logic [3:0]        O_H_CNT,
    output logic              O_MEM_REQ,
    output logic [AW-2:0]     O_MEM_ADDR,
    input  logic              I_MEM_ACK,
    input  logic [15:0]       I_MEM_DATA
);
    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t                   state;
    logic [NCH-1:0][AW-1:0]   ch_addr;
    logic [NCH-1:0]           hit, miss, fill;
    logic [2*NCH-1:0]         dbl;
    logic [NCH-1:0]           rot;
    logic [2:0]               ptr, gnt, off, sel, ptr_nxt;
    logic [3:0]               sum, sel_p1;
    logic                     sel_vld;
    logic                     discard;

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) O_H_CNT <= '0;
        else         O_H_CNT <= O_H_CNT + 4'd1;
    end

    genvar n;
    generate
        for (n = 0; n < NCH; n++) begin : g_lane
            assign ch_addr[n] = I_CH_ADDR[n*AW +: AW];
            // A discarded or invalidated fill never reaches the cache.
            assign fill[n] = (state == ST_REQ) && I_MEM_ACK && !discard &&
                             !I_INVALIDATE && (gnt == 3'(n));
            wave_rom_lane #(.AW(AW)) u_lane (
                .I_CLK        (I_CLK),
                .I_RSTn       (I_RSTn),
                .I_ADDR       (ch_addr[n]),
                .I_INVALIDATE (I_INVALIDATE),
                .I_FILL       (fill[n]),
                .I_FILL_WORD  (I_MEM_DATA),
                .I_FILL_TAG   (O_MEM_ADDR),
                .O_HIT        (hit[n]),
                .O_READY      (O_CH_READY[n]),
                .O_DATA       (O_CH_DATA[n*8 +: 8])
            );
        end
    endgenerate

    assign miss = I_CH_READ & ~hit;

    // Rotate the miss vector so bit 0 is the pointer channel, then take the
    // lowest set bit: first miss at or after the pointer, wrapping.
    assign dbl = {miss, miss} >> ptr;

    always_comb begin
        rot     = dbl[NCH-1:0];
        off     = '0;
        sel_vld = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off     = 3'(i);
                sel_vld = 1'b1;
            end
        end
        sum     = {1'b0, ptr} + {1'b0, off};
        sel     = (sum >= 4'(NCH)) ? 3'(sum - 4'(NCH)) : sum[2:0];
        sel_p1  = {1'b0, sel} + 4'd1;
        ptr_nxt = (sel_p1 >= 4'(NCH)) ? 3'd0 : sel_p1[2:0];
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state      <= ST_IDLE;
            O_MEM_REQ  <= 1'b0;
            O_MEM_ADDR <= '0;
            gnt        <= '0;
            ptr        <= '0;
            discard    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    discard <= 1'b0;
                    if (sel_vld) begin
                        gnt        <= sel;
                        O_MEM_ADDR <= ch_addr[sel][AW-1:1];
                        O_MEM_REQ  <= 1'b1;
                        ptr        <= ptr_nxt;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The bus cycle must still be closed by the ack even when
                    // the ROM was reloaded underneath it.
                    if (I_INVALIDATE) discard <= 1'b1;
                    if (I_MEM_ACK) begin
                        O_MEM_REQ <= 1'b0;
                        discard   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_rom_fetch.sv
// Bench for wave_rom_fetch: scripted channel traffic, a delayed-ack memory
// model, and a queue of expected request word addresses.

module tb_wave_rom_fetch;
    localparam int NCH = 8;
    localparam int AW  = 28;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_read;
    logic [NCH*AW-1:0] ch_addr;
    logic              inv;
    logic [NCH*8-1:0]  ch_data;
    logic [NCH-1:0]    ch_ready;
    logic [3:0]        h_cnt;
    logic              mem_req;
    logic [AW-2:0]     mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_data;

    int             n_chk  = 0;
    int             n_fail = 0;
    int             ack_dly = 5;
    logic [AW-2:0]  exp_q[$];

    wave_rom_fetch #(.NCH(NCH), .AW(AW)) dut (
        .I_CLK        (clk),
        .I_RSTn       (rst_n),
        .I_CH_READ    (ch_read),
        .I_CH_ADDR    (ch_addr),
        .I_INVALIDATE (inv),
        .O_CH_DATA    (ch_data),
        .O_CH_READY   (ch_ready),
        .O_H_CNT      (h_cnt),
        .O_MEM_REQ    (mem_req),
        .O_MEM_ADDR   (mem_addr),
        .I_MEM_ACK    (mem_ack),
        .I_MEM_DATA   (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [AW-2:0] w);
        if (w == 27'h080) return 16'hBEEF;
        return {w[7:0] ^ 8'h5A, w[7:0] ^ 8'hC3};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int n, input logic rd, input logic [AW-1:0] a);
        ch_read[n] = rd;
        ch_addr[n*AW +: AW] = a;
    endtask

    task automatic chk_ch(input int n, input logic [AW-1:0] a);
        logic [15:0] w;
        w = mem_fn(a[AW-1:1]);
        chk($sformatf("ready%0d", n), 32'(ch_ready[n]), 1);
        chk($sformatf("data%0d", n), 32'(ch_data[n*8 +: 8]), 32'(a[0] ? w[15:8] : w[7:0]));
    endtask

    task automatic wait_ready(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ch_ready[n]) break;
        end
        chk($sformatf("rdy_to%0d", n), 32'(ch_ready[n]), 1);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("req_to", 32'(mem_req), 1);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (mem_ack) break;
        end
        chk("ack_to", 32'(mem_ack), 1);
    endtask

    // Memory model: acks ack_dly cycles into each request; each new request
    // is matched against the head of the expected-address queue.
    initial begin
        int  cnt;
        bit  seen;
        mem_ack  = 1'b0;
        mem_data = '0;
        cnt  = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0;
                cnt     = 0;
                seen    = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                seen    = 1'b0;
            end else if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    cnt  = 0;
                    if (exp_q.size() == 0) chk("req_unexp", 32'(exp_q.size()), 1);
                    else chk("req_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
                end
                cnt++;
                if (cnt >= ack_dly) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_fn(mem_addr);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        ch_read = '0;
        ch_addr = '0;
        inv     = 1'b0;
        #2;
        chk("rst_hcnt", 32'(h_cnt), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        chk("rst_ready", 32'(ch_ready), 0);
        chk("rst_data", ch_data[31:0], 0);
        chk("rst_data_hi", ch_data[63:32], 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Slot counter free-runs and wraps; no requests without reads.
        for (int k = 0; k <= 16; k++) begin
            chk("hcnt", 32'(h_cnt), 32'(k % 16));
            chk("idle_req", 32'(mem_req), 0);
            @(negedge clk);
        end

        // Single miss then same-word hit on the odd byte.
        ack_dly = 5;
        exp_q.push_back(27'h080);
        set_ch(0, 1'b1, 28'h100);
        wait_ready(0);
        chk_ch(0, 28'h100);
        set_ch(0, 1'b1, 28'h101);
        @(negedge clk);
        chk_ch(0, 28'h101);
        chk("hit_noreq", 32'(mem_req), 0);

        // Simultaneous misses served round-robin in channel order.
        ack_dly = 2;
        exp_q.push_back(27'h0800);
        exp_q.push_back(27'h1000);
        exp_q.push_back(27'h1800);
        set_ch(2, 1'b1, 28'h1000);
        set_ch(5, 1'b1, 28'h2000);
        set_ch(7, 1'b1, 28'h3000);
        wait_ready(2);
        wait_ready(5);
        wait_ready(7);
        chk_ch(2, 28'h1000);
        chk_ch(5, 28'h2000);
        chk_ch(7, 28'h3000);

        // Ch2 alone moves the pointer to 3; then ch5 outranks ch2.
        exp_q.push_back(27'h0880);
        set_ch(2, 1'b1, 28'h1100);
        wait_ready(2);
        chk_ch(2, 28'h1100);
        exp_q.push_back(27'h1080);
        exp_q.push_back(27'h08C0);
        set_ch(2, 1'b1, 28'h1180);
        set_ch(5, 1'b1, 28'h2100);
        wait_ready(5);
        wait_ready(2);
        chk_ch(5, 28'h2100);
        chk_ch(2, 28'h1180);

        // Address moves while the fill is outstanding.
        ack_dly = 6;
        exp_q.push_back(27'h100);
        exp_q.push_back(27'h200);
        set_ch(1, 1'b1, 28'h200);
        wait_req();
        set_ch(1, 1'b1, 28'h400);
        wait_ack();
        @(negedge clk);
        @(negedge clk);
        chk("stale_fill_rdy", 32'(ch_ready[1]), 0);
        wait_ready(1);
        chk_ch(1, 28'h400);

        // Invalidate during a pending fill.
        ch_read = '0;
        exp_q.push_back(27'h300);
        exp_q.push_back(27'h300);
        set_ch(3, 1'b1, 28'h600);
        wait_req();
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        wait_ack();
        @(negedge clk);
        @(negedge clk);
        chk("inv_ready", 32'(ch_ready), 0);
        wait_ready(3);
        chk_ch(3, 28'h600);

        // Asynchronous reset in the middle of a request.
        ch_read = '0;
        ack_dly = 20;
        exp_q.push_back(27'h400);
        set_ch(4, 1'b1, 28'h800);
        wait_req();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 0);
        chk("arst_ready", 32'(ch_ready), 0);
        chk("arst_hcnt", 32'(h_cnt), 0);
        ch_read = '0;
        @(negedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_req", 32'(mem_req), 0);
        end
        exp_q.push_back(27'h400);
        set_ch(4, 1'b1, 28'h800);
        wait_ready(4);
        chk_ch(4, 28'h800);
        chk("q_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
